// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - four-digit multiplexed seven-segment scanner showing a synchronised pattern and its change count
module seg_scan_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       change_pulse,
  output logic [7:0] change_cnt
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [7:0]    sync1, sync2, sync3;
  logic [7:0]    disp_reg;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit_idx;
  logic          accept;
  logic          blank;
  logic [3:0]    digit_val;
  logic [6:0]    digit_seg;

  // sync3 is an extra stage so a value must be seen twice before it is trusted
  assign accept = (sync2 == sync3) && (sync2 != disp_reg);
  assign blank  = scan_cnt < BLANK_END;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
      sync3 <= 8'h00;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_reg     <= 8'h00;
      change_cnt   <= 8'h00;
      change_pulse <= 1'b0;
    end else begin
      change_pulse <= accept;
      if (accept) begin
        disp_reg   <= sync2;
        change_cnt <= change_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    digit_val = disp_reg[3:0];
    case (digit_idx)
      2'd0: digit_val = disp_reg[3:0];
      2'd1: digit_val = disp_reg[7:4];
      2'd2: digit_val = change_cnt[3:0];
      2'd3: digit_val = change_cnt[7:4];
      default: digit_val = disp_reg[3:0];
    endcase
  end

  always_comb begin
    digit_seg = 7'h7F;
    case (digit_val)
      4'h0: digit_seg = 7'h40;
      4'h1: digit_seg = 7'h79;
      4'h2: digit_seg = 7'h24;
      4'h3: digit_seg = 7'h30;
      4'h4: digit_seg = 7'h19;
      4'h5: digit_seg = 7'h12;
      4'h6: digit_seg = 7'h02;
      4'h7: digit_seg = 7'h78;
      4'h8: digit_seg = 7'h00;
      4'h9: digit_seg = 7'h10;
      4'hA: digit_seg = 7'h08;
      4'hB: digit_seg = 7'h03;
      4'hC: digit_seg = 7'h46;
      4'hD: digit_seg = 7'h21;
      4'hE: digit_seg = 7'h06;
      4'hF: digit_seg = 7'h0E;
      default: digit_seg = 7'h7F;
    endcase
  end

  // Segments are dark during blanking so the previous digit cannot ghost onto the new anode
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (blank) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= digit_seg;
      dp  <= (digit_idx != 2'd2);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display against a cycle-position reference model
module tb_seg_scan_display;

  localparam int SD = 16;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       change_pulse;
  logic [7:0] change_cnt;

  seg_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .an(an), .seg(seg),
    .dp(dp), .change_pulse(change_pulse), .change_cnt(change_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       seg_valid;
    logic       dp;
    logic       pulse;
    logic [7:0] cnt;
  } exp_t;

  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];
  logic [7:0] pulse_q[$];
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: samples seen at each edge, value on display, count, edges since reset
  logic [7:0] hist[$];
  logic [7:0] m_disp = 8'h00;
  logic [7:0] m_cnt = 8'h00;
  int         m_pos = 0;
  exp_t       mon_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [7:0] d);
    exp_t       e;
    int         slot, off;
    logic       lit;
    logic [3:0] nib;
    logic [3:0] onehot;
    if (r) begin
      hist = '{8'h00, 8'h00, 8'h00};
      m_disp = 8'h00;
      m_cnt = 8'h00;
      m_pos = 0;
      e = '{an: 4'hF, seg: 7'h7F, seg_valid: 1'b1, dp: 1'b1, pulse: 1'b0, cnt: 8'h00};
    end else begin
      slot = (m_pos / SD) % 4;
      off  = m_pos % SD;
      lit  = (off >= BC);
      case (slot)
        0: nib = m_disp[3:0];
        1: nib = m_disp[7:4];
        2: nib = m_cnt[3:0];
        default: nib = m_cnt[7:4];
      endcase
      onehot = 4'b0001 << slot;
      e.an        = lit ? ~onehot : 4'hF;
      e.seg       = hex_tab[nib];
      e.seg_valid = lit;
      e.dp        = !(lit && slot == 2);
      hist.push_front(d);
      if (hist.size() > 4) void'(hist.pop_back());
      // a value counts once it was seen on two consecutive samples, two edges back
      if (hist[2] == hist[3] && hist[2] != m_disp) begin
        m_disp = hist[2];
        m_cnt  = m_cnt + 8'd1;
        e.pulse = 1'b1;
        pulse_q.push_back(m_cnt);
      end else begin
        e.pulse = 1'b0;
      end
      e.cnt = m_cnt;
      m_pos++;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick(input logic r, input logic [7:0] d);
    reset   = r;
    data_in = d;
    @(posedge clk);
    #1;
    model_step(r, d);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("an", {28'h0, an}, {28'h0, mon_e.an});
      if (mon_e.seg_valid) check("seg", {25'h0, seg}, {25'h0, mon_e.seg});
      check("dp", {31'h0, dp}, {31'h0, mon_e.dp});
      check("change_pulse", {31'h0, change_pulse}, {31'h0, mon_e.pulse});
      check("change_cnt", {24'h0, change_cnt}, {24'h0, mon_e.cnt});
    end
    if (change_pulse === 1'b1) begin
      if (pulse_q.size() > 0) check("pulse_cnt", {24'h0, change_cnt}, {24'h0, pulse_q.pop_front()});
      else check("pulse_unexpected", {31'h0, change_pulse}, 32'h0);
    end
  end

  initial begin
    logic [7:0] v;
    int         hold;

    repeat (3) tick(1'b1, 8'($urandom));
    check("reset_an", {28'h0, an}, 32'hF);
    check("reset_seg", {25'h0, seg}, 32'h7F);
    check("reset_dp", {31'h0, dp}, 32'h1);
    check("reset_cnt", {24'h0, change_cnt}, 32'h0);
    check("reset_pulse", {31'h0, change_pulse}, 32'h0);

    repeat (70) tick(1'b0, 8'h01);
    check("first_cnt", {24'h0, change_cnt}, 32'h1);

    tick(1'b0, 8'h80);
    repeat (12) tick(1'b0, 8'h01);
    check("glitch_cnt", {24'h0, change_cnt}, 32'h1);

    for (int i = 0; i < 60; i++) begin
      v = 8'($urandom);
      hold = $urandom_range(1, 6);
      repeat (hold) tick(1'b0, v);
    end

    while (((m_pos / SD) % 4) != 2 || (m_pos % SD) < 5) tick(1'b0, 8'h05);
    tick(1'b0, 8'h09);
    tick(1'b0, 8'h09);
    tick(1'b1, 8'h09);
    check("midslot_reset_an", {28'h0, an}, 32'hF);
    repeat (70) tick(1'b0, 8'h09);

    repeat (2) tick(1'b1, 8'h00);
    for (int i = 0; i < 256; i++) repeat (8) tick(1'b0, (i % 2 == 0) ? 8'h01 : 8'h02);
    repeat (70) tick(1'b0, 8'h02);
    check("wrap_cnt", {24'h0, change_cnt}, 32'h0);

    repeat (2) @(negedge clk);
    check("pulses_seen", pulse_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 16..2^20.
REQ-002 The block SHALL have parameter BLANK_CYC, default 8: leading cycles of each slot with all anodes off; legal range 1..SCAN_DIV-8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, 50 MHz board clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, 8 bits: the rotating LED pattern, asynchronous to clk because it is produced in the divided-clock domain.
REQ-006 The block SHALL have port an, output, 4 bits: digit anodes, active-low; an[0] is the rightmost digit.
REQ-007 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-008 The block SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-009 The block SHALL have port change_pulse, output, 1 bit: one-cycle strobe, high for the cycle after each accepted pattern change.
REQ-010 The block SHALL have port change_cnt, output, 8 bits: the count of accepted pattern changes.

Function
REQ-011 data_in SHALL pass through three flops, sync1 <= data_in, sync2 <= sync1 and sync3 <= sync2, and SHALL be used nowhere else.
REQ-012 A value SHALL be accepted when sync2 == sync3 and sync2 != disp_reg; on acceptance disp_reg <= sync2.
REQ-013 Acceptance latency: a change that is stable from the sampling edge (edge 1) SHALL appear in disp_reg at edge 4.
REQ-014 A data_in value held for only one cycle SHALL never be accepted.
REQ-015 On each acceptance, change_cnt SHALL increment by 1, wrapping from 255 to 0, and change_pulse SHALL be high for exactly the following cycle.
REQ-016 A stable data_in equal to disp_reg SHALL produce no pulse and no increment.
REQ-017 scan_cnt SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 it SHALL wrap to 0 and digit_idx SHALL advance 0->1->2->3->0.
REQ-018 Digit sources: idx0 = disp_reg[3:0], idx1 = disp_reg[7:4], idx2 = change_cnt[3:0], idx3 = change_cnt[7:4].
REQ-019 Hex-to-segment mapping (active-low) SHALL be: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-020 an, seg and dp SHALL be registered, with one cycle of latency from scan_cnt and digit_idx.
REQ-021 Blanking: when the registered scan_cnt < BLANK_CYC, an SHALL be 4'b1111.
REQ-022 Outside blanking, an SHALL be the one-hot low bit for digit_idx (idx0 = 4'b1110 ... idx3 = 4'b0111), and seg SHALL be the decoded digit.
REQ-023 dp SHALL be 0 only while digit 2 is lit, separating the pattern from the count; otherwise dp SHALL be 1.
REQ-024 The digit source SHALL be sampled live, so an acceptance mid-slot SHALL update seg within 1 cycle.

Reset
REQ-025 While reset is high at a clk edge, the following SHALL be cleared to 0: sync1-3, disp_reg, change_cnt, scan_cnt and digit_idx.
REQ-026 While reset is high at a clk edge: change_pulse = 0, an = 4'b1111, seg = 7'h7F, dp = 1.
REQ-027 Reset mid-slot or mid-acceptance SHALL abort it; no pulse and no increment shall occur for an in-flight value.
REQ-028 After reset deasserts, scanning SHALL restart at digit 0, slot start (blanked).

Verification
REQ-029 Bench SHALL use SCAN_DIV=16, BLANK_CYC=2.
REQ-030 Reset for 3 cycles -> an=1111, seg=7F, dp=1, change_cnt=00, change_pulse=0.
REQ-031 After reset, data_in=8'h01 held -> disp_reg=01 at edge 4, change_pulse high 1 cycle, change_cnt=01; digits 0..3 show seg 79, 40, 79, 40, with dp=0 only on digit 2.
REQ-032 With disp_reg=01, data_in=8'h80 for exactly one cycle, then back to 8'h01 -> disp_reg stays 01, no pulse, change_cnt unchanged.
REQ-033 Free-running scan -> an cycles 1110, 1101, 1011, 0111; each is low for 14 cycles, preceded by 2 cycles of 1111; the period is 64 cycles.
REQ-034 256 accepted changes alternating 8'h01 / 8'h02 (each held 8 cycles) -> change_cnt wraps to 00, and digits 2 and 3 show seg 40.
REQ-035 Reset asserted while digit 2 is lit -> an=1111 on the next edge; after release, the first lit digit is digit 0 (an=1110) after 2 blank cycles.
